exec_issue_ctrl: RTL and testbench

Issue controller that sequences the Execute unit. Accepts operation requests from decode over a valid/ready handshake and drives enable_ex and control_in into Execute. Handles loads by waiting on memory with a bounded timeout, and pulses mem_write_en for stores. Flags result availability to writeback and freezes issue on a downstream stall.

---
 rtl/exec_ctrl_pkg.sv | 47 ++++
 rtl/exec_result_pipe.sv | 22 ++
 rtl/exec_issue_ctrl.sv | 111 +++++++++++
 tb/tb_exec_issue_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and encodings for the Execute issue controller.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,
        CLS_SHIFT = 2'd1,
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } op_class_e;

    localparam logic [2:0] OPSEL_ALU   = 3'b001;
    localparam logic [2:0] OPSEL_SHIFT = 3'b000;
    localparam logic [2:0] OPSEL_LOAD  = 3'b101;
    localparam logic [2:0] OPSEL_STORE = 3'b100;

    typedef struct packed {
        logic       use_imm;
        logic [2:0] opselect;
        logic [2:0] operation;
    } control_word_t;

    typedef struct packed {
        op_class_e  cls;
        logic [2:0] op;
        logic       use_imm;
    } op_t;

    function automatic logic [2:0] class_to_opsel(input op_class_e c);
        logic [2:0] sel;
        sel = OPSEL_ALU;
        case (c)
            CLS_ALU:   sel = OPSEL_ALU;
            CLS_SHIFT: sel = OPSEL_SHIFT;
            CLS_LOAD:  sel = OPSEL_LOAD;
            CLS_STORE: sel = OPSEL_STORE;
            default:   sel = OPSEL_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exec_result_pipe.sv
// EX_LAT-deep valid shift register: flags when Execute's aluout is ready.
module exec_result_pipe #(
    parameter int EX_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic valid_i,
    output logic valid_o
);

    logic [EX_LAT-1:0] pipe_q;
    logic [EX_LAT:0]   pipe_d;

    assign pipe_d  = {pipe_q, valid_i};
    assign valid_o = pipe_q[EX_LAT-1];

    always_ff @(posedge clock) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d[EX_LAT-1:0];
    end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue controller: accepts decode ops, waits on memory for loads (with
// timeout), drives Execute enable/control and tracks result availability.
module exec_issue_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int EX_LAT      = 1,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_class,
    input  logic [2:0]       req_op,
    input  logic             req_use_imm,
    input  logic             wb_stall,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             enable_ex,
    output logic [6:0]       control_in,
    output logic             mem_write_en,
    output logic             result_valid,
    output logic             err_timeout,
    output logic [CNT_W-1:0] issue_count
);

    localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    op_t               op_q, op_d, new_op;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    state_e            accept_dest;
    control_word_t     cw;

    assign new_op      = '{cls: op_class_e'(req_class), op: req_op, use_imm: req_use_imm};
    assign accept_dest = (new_op.cls == CLS_LOAD) ? ST_MEM_WAIT : ST_ISSUE;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tmo_d     = '0;
        err_d     = err_q;
        req_ready = !wb_stall && (state_q == ST_IDLE || state_q == ST_ISSUE);
        accept    = req_valid && req_ready;
        enable_ex = (state_q == ST_ISSUE) && !wb_stall;
        mem_req   = (state_q == ST_MEM_WAIT);

        if (accept) op_d = new_op;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = accept_dest;
            end
            ST_ISSUE: begin
                // A stalled ISSUE holds its op; otherwise issue and take the next one.
                if (!wb_stall) state_d = accept ? accept_dest : ST_IDLE;
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_ISSUE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    op_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_d = cnt_q + CNT_W'(enable_ex);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cw = '{use_imm: op_q.use_imm, opselect: class_to_opsel(op_q.cls), operation: op_q.op};

    // Control word is only presented while an op sits in ISSUE.
    assign control_in   = (state_q == ST_ISSUE) ? cw : '0;
    assign mem_write_en = enable_ex && (op_q.cls == CLS_STORE);
    assign err_timeout  = err_q;
    assign issue_count  = cnt_q;

    exec_result_pipe #(.EX_LAT(EX_LAT)) u_result_pipe (
        .clock   (clock),
        .reset   (reset),
        .valid_i (enable_ex && (op_q.cls != CLS_STORE)),
        .valid_o (result_valid)
    );

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed table-driven bench for exec_issue_ctrl (EX_LAT=1, MEM_TIMEOUT=8).
module tb_exec_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, req_use_imm, wb_stall, mem_ack;
    logic [1:0]  req_class;
    logic [2:0]  req_op;
    logic        mem_req, enable_ex, mem_write_en, result_valid, err_timeout;
    logic [6:0]  control_in;
    logic [15:0] issue_count;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    exec_issue_ctrl #(.EX_LAT(1), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_op(req_op), .req_use_imm(req_use_imm),
        .wb_stall(wb_stall), .mem_ack(mem_ack), .mem_req(mem_req),
        .enable_ex(enable_ex), .control_in(control_in), .mem_write_en(mem_write_en),
        .result_valid(result_valid), .err_timeout(err_timeout), .issue_count(issue_count)
    );

    typedef struct {
        logic        rst, v;
        logic [1:0]  cls;
        logic [2:0]  op;
        logic        imm, stall, ack;
        logic        rdy, en;
        logic [6:0]  ctl;
        logic        mreq, mwe, rv, err;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input logic rst, v, input logic [1:0] cls, input logic [2:0] op,
                               input logic imm, stall, ack, rdy, en, input logic [6:0] ctl,
                               input logic mreq, mwe, rv, err, input logic [15:0] cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.cls = cls; r.op = op; r.imm = imm; r.stall = stall; r.ack = ack;
        r.rdy = rdy; r.en = en; r.ctl = ctl; r.mreq = mreq; r.mwe = mwe; r.rv = rv; r.err = err;
        r.cnt = cnt;
        return r;
    endfunction

    // Drive one cycle's inputs mid-cycle, then let outputs settle before checking.
    task automatic step(input logic rst, v, input logic [1:0] cls, input logic [2:0] op,
                        input logic imm, stall, ack);
        @(negedge clock);
        reset = rst; req_valid = v; req_class = cls; req_op = op;
        req_use_imm = imm; wb_stall = stall; mem_ack = ack;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] act_w, exp_w;
    int          n;
    logic        done;

    initial begin
        reset = 1'b1; req_valid = 1'b1; req_class = 2'd0; req_op = 3'd0;
        req_use_imm = 1'b0; wb_stall = 1'b0; mem_ack = 1'b0;
        @(posedge clock);

        // reset held with req_valid up, then ALU back-to-back
        tbl.push_back(V(1,1,0,0,0,0,0, 1,0,7'h00,0,0,0,0,0));
        tbl.push_back(V(1,1,0,0,0,0,0, 1,0,7'h00,0,0,0,0,0));
        tbl.push_back(V(0,1,0,0,0,0,0, 1,0,7'h00,0,0,0,0,0));
        tbl.push_back(V(0,1,0,2,0,0,0, 1,1,7'h08,0,0,0,0,0));
        tbl.push_back(V(0,1,0,4,0,0,0, 1,1,7'h0A,0,0,1,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,1,7'h0C,0,0,1,0,2));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,1,0,3));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,0,0,3));
        // LOAD acked in 3rd MEM_WAIT cycle
        tbl.push_back(V(0,1,2,1,0,0,0, 1,0,7'h00,0,0,0,0,3));
        tbl.push_back(V(0,0,0,0,0,0,0, 0,0,7'h00,1,0,0,0,3));
        tbl.push_back(V(0,0,0,0,0,0,0, 0,0,7'h00,1,0,0,0,3));
        tbl.push_back(V(0,0,0,0,0,0,1, 0,0,7'h00,1,0,0,0,3));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,1,7'h29,0,0,0,0,3));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,1,0,4));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,0,0,4));
        // LOAD timeout; decode keeps presenting an ALU op that must not be taken
        tbl.push_back(V(0,1,2,0,0,0,0, 1,0,7'h00,0,0,0,0,4));
        for (int i = 0; i < 8; i++)
            tbl.push_back(V(0,1,0,0,0,0,0, 0,0,7'h00,1,0,0,0,4));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,0,1,4));
        tbl.push_back(V(1,0,0,0,0,0,0, 1,0,7'h00,0,0,0,1,4));
        // LOAD acked on the final allowed cycle
        tbl.push_back(V(0,1,2,3,0,0,0, 1,0,7'h00,0,0,0,0,0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(V(0,0,0,0,0,0,0, 0,0,7'h00,1,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,1, 0,0,7'h00,1,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,1,7'h2B,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,1,0,1));
        // STORE stalled 2 cycles in ISSUE
        tbl.push_back(V(0,1,3,5,1,0,0, 1,0,7'h00,0,0,0,0,1));
        tbl.push_back(V(0,0,0,0,0,1,0, 0,0,7'h65,0,0,0,0,1));
        tbl.push_back(V(0,0,0,0,0,1,0, 0,0,7'h65,0,0,0,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,1,7'h65,0,1,0,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,0,0,2));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,0,0,2));
        // reset in 2nd MEM_WAIT cycle, late ack ignored
        tbl.push_back(V(0,1,2,0,0,0,0, 1,0,7'h00,0,0,0,0,2));
        tbl.push_back(V(0,0,0,0,0,0,0, 0,0,7'h00,1,0,0,0,2));
        tbl.push_back(V(1,0,0,0,0,0,0, 0,0,7'h00,1,0,0,0,2));
        tbl.push_back(V(0,0,0,0,0,0,1, 1,0,7'h00,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,0,0,0));
        // stall in IDLE blocks accept
        tbl.push_back(V(0,1,0,0,0,1,0, 0,0,7'h00,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0, 1,0,7'h00,0,0,0,0,0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].cls, tbl[i].op, tbl[i].imm, tbl[i].stall, tbl[i].ack);
            act_w = {2'b0, req_ready, enable_ex, control_in, mem_req, mem_write_en,
                     result_valid, err_timeout, issue_count};
            exp_w = {2'b0, tbl[i].rdy, tbl[i].en, tbl[i].ctl, tbl[i].mreq, tbl[i].mwe,
                     tbl[i].rv, tbl[i].err, tbl[i].cnt};
            chk($sformatf("row%0d", i), act_w, exp_w);
        end

        // Pending result dropped by reset during the enable cycle
        step(0,1,0,1,0,0,0);
        step(1,0,0,0,0,0,0);
        chk("rst_en_cycle", {31'b0, enable_ex}, 32'd1);
        step(0,0,0,0,0,0,0);
        chk("rst_drop_rv", {31'b0, result_valid}, 32'd0);
        chk("rst_drop_rdy", {31'b0, req_ready}, 32'd1);

        // ALU then LOAD back-to-back from ISSUE
        step(0,1,1,3,1,0,0);
        step(0,1,2,6,0,0,0);
        chk("b2b_shift_ctl", {25'b0, control_in}, 32'h43);
        step(0,0,0,0,0,0,0);
        chk("b2b_load_mreq", {31'b0, mem_req}, 32'd1);
        chk("b2b_shift_rv", {31'b0, result_valid}, 32'd1);
        step(0,0,0,0,0,0,1);
        step(0,0,0,0,0,0,0);
        chk("b2b_load_ctl", {24'b0, enable_ex, control_in}, 32'hAE);

        // Timeout length measured with a bounded wait
        step(0,0,0,0,0,0,0);
        step(0,1,2,0,0,0,0);
        n = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step(0,0,0,0,0,0,0);
            if (mem_req) n++;
            else done = 1'b1;
        end
        chk("tmo_done", {31'b0, done}, 32'd1);
        chk("tmo_len", n, 32'd8);
        chk("tmo_err", {30'b0, err_timeout, enable_ex}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
